// File: rtl/rq_pkg.sv
// rq_pkg: types shared between the request queue and its dispatcher.
//   DispatchState - dispatcher FSM encoding
//   SlotId        - slot index for the default queue size
package rq_pkg;

  localparam int RQ_LSIZE = 4;

  typedef logic [RQ_LSIZE-1:0] SlotId;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    OUT     = 2'd3
  } DispatchState;

endpackage

// File: rtl/dispatch_slot_fifo.sv
// dispatch_slot_fifo: 2**LSIZE-deep FIFO of slot ids, first-word fall-through.
//   clk, reset    - clock, async active-low reset
//   wr_en/wr_data - push; ignored when full
//   rd_en         - pop the head; ignored when empty
//   rd_data       - current head
//   count/full/empty - occupancy
module dispatch_slot_fifo #(
  parameter int LSIZE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [LSIZE-1:0] wr_data,
  input  logic             rd_en,
  output logic [LSIZE-1:0] rd_data,
  output logic [LSIZE:0]   count,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << LSIZE;

  logic [LSIZE-1:0] mem_q [DEPTH];
  logic [LSIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LSIZE:0]   count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full  = (count_q == (LSIZE+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // Pointers are LSIZE bits wide, so increment wraps modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (!wr_ok && rd_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/request_dispatcher.sv
// request_dispatcher: buffers slot ids of stored requests and dispatches them
// in arrival order. For each id it presents the slot address to the queue,
// captures the read data one cycle later, frees the slot (pop_en_out) and
// holds the payload on a valid/ready output until accepted.
//   clk, reset             - clock, async active-low reset
//   initialized_in         - gate for starting a dispatch
//   slot_valid_in/_id_in   - new request notification
//   pop_slot_id_out/pop_en_out/pop_data_in - queue read/free port
//   req_valid_out/req_ready_in/req_data_out/req_slot_id_out - downstream
//   pending_count_out      - ids waiting in the FIFO
//   error                  - sticky overflow
module request_dispatcher
  import rq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LSIZE      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  initialized_in,
  input  logic                  slot_valid_in,
  input  logic [LSIZE-1:0]      slot_id_in,
  output logic [LSIZE-1:0]      pop_slot_id_out,
  output logic                  pop_en_out,
  input  logic [DATA_WIDTH-1:0] pop_data_in,
  output logic                  req_valid_out,
  input  logic                  req_ready_in,
  output logic [DATA_WIDTH-1:0] req_data_out,
  output logic [LSIZE-1:0]      req_slot_id_out,
  output logic [LSIZE:0]        pending_count_out,
  output logic                  error
);
  DispatchState          state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LSIZE-1:0]      slot_q, slot_d;
  logic                  error_q, error_d;
  logic                  fifo_rd, fifo_full, fifo_empty;
  logic [LSIZE-1:0]      fifo_head;

  dispatch_slot_fifo #(.LSIZE(LSIZE)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (slot_valid_in),
    .wr_data (slot_id_in),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .count   (pending_count_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d         = state_q;
    data_d          = data_q;
    slot_d          = slot_q;
    error_d         = error_q | (slot_valid_in & fifo_full);
    fifo_rd         = 1'b0;
    pop_en_out      = 1'b0;
    pop_slot_id_out = '0;
    case (state_q)
      IDLE: if (!fifo_empty && initialized_in) state_d = READ;
      READ: begin
        pop_slot_id_out = fifo_head;
        state_d         = CAPTURE;
      end
      CAPTURE: begin
        // Queue data for the address driven in READ arrives now.
        pop_slot_id_out = fifo_head;
        pop_en_out      = 1'b1;
        fifo_rd         = 1'b1;
        data_d          = pop_data_in;
        slot_d          = fifo_head;
        state_d         = OUT;
      end
      OUT: if (req_ready_in) begin
        // A same-cycle push counts: it is readable as head next cycle.
        if ((!fifo_empty || slot_valid_in) && initialized_in) state_d = READ;
        else                                                   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      slot_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      slot_q  <= slot_d;
      error_q <= error_d;
    end
  end

  assign req_valid_out   = (state_q == OUT);
  assign req_data_out    = data_q;
  assign req_slot_id_out = slot_q;
  assign error           = error_q;

endmodule

// File: tb/tb_request_dispatcher.sv
module tb_request_dispatcher;
  logic       clk = 1'b0;
  logic       reset;
  // main instance, LSIZE=4
  logic       init, sv, ready, pop_en, valid, err;
  logic [3:0] sid, pop_slot, rslot;
  logic [7:0] pdata, rdata;
  logic [4:0] cnt;
  // overflow instance, LSIZE=2
  logic       b_init, b_sv, b_ready, b_pop_en, b_valid, b_err;
  logic [1:0] b_sid, b_pop_slot, b_rslot;
  logic [7:0] b_pdata, b_rdata;
  logic [2:0] b_cnt;

  int checks = 0;
  int errors = 0;
  int n, bad, pushed, mism;
  logic [3:0] got [0:63];

  always #5 clk = ~clk;

  request_dispatcher #(.DATA_WIDTH(8), .LSIZE(4)) dut (
    .clk(clk), .reset(reset), .initialized_in(init), .slot_valid_in(sv),
    .slot_id_in(sid), .pop_slot_id_out(pop_slot), .pop_en_out(pop_en),
    .pop_data_in(pdata), .req_valid_out(valid), .req_ready_in(ready),
    .req_data_out(rdata), .req_slot_id_out(rslot),
    .pending_count_out(cnt), .error(err)
  );

  request_dispatcher #(.DATA_WIDTH(8), .LSIZE(2)) dut_b (
    .clk(clk), .reset(reset), .initialized_in(b_init), .slot_valid_in(b_sv),
    .slot_id_in(b_sid), .pop_slot_id_out(b_pop_slot), .pop_en_out(b_pop_en),
    .pop_data_in(b_pdata), .req_valid_out(b_valid), .req_ready_in(b_ready),
    .req_data_out(b_rdata), .req_slot_id_out(b_rslot),
    .pending_count_out(b_cnt), .error(b_err)
  );

  // Queue model: read data for slot s is 0xA2+s, one cycle after the address.
  always @(posedge clk) begin
    pdata   <= 8'hA2 + {4'h0, pop_slot};
    b_pdata <= 8'hA2 + {6'h0, b_pop_slot};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; init = 0; sv = 0; sid = '0; ready = 0;
    b_init = 0; b_sv = 0; b_sid = '0; b_ready = 0;
    #3;
    chk("rst_pop_en",   32'(pop_en), 0);
    chk("rst_valid",    32'(valid), 0);
    chk("rst_err",      32'(err), 0);
    chk("rst_cnt",      32'(cnt), 0);
    chk("rst_pop_slot", 32'(pop_slot), 0);
    chk("rst_rdata",    32'(rdata), 0);
    chk("rst_rslot",    32'(rslot), 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Overflow on the 4-deep instance: 5th id dropped, error sticky.
    b_sv = 1;
    b_sid = 2'd1; tick();
    b_sid = 2'd2; tick();
    b_sid = 2'd3; tick();
    b_sid = 2'd0; tick();
    b_sid = 2'd2; tick();
    b_sv = 0; tick();
    chk("ovf_cnt", 32'(b_cnt), 4);
    chk("ovf_err", 32'(b_err), 1);
    b_init = 1; b_ready = 1; n = 0;
    repeat (30) begin
      if (b_valid) begin got[n] = {2'b00, b_rslot}; n++; end
      tick();
    end
    chk("ovf_ndisp", 32'(n), 4);
    chk("ovf_o0", 32'(got[0]), 1);
    chk("ovf_o1", 32'(got[1]), 2);
    chk("ovf_o2", 32'(got[2]), 3);
    chk("ovf_o3", 32'(got[3]), 0);
    chk("ovf_err_hold", 32'(b_err), 1);

    // Basic latency: push at t, pop_en at t+3, valid at t+4.
    init = 1; sv = 1; sid = 4'd3; tick();
    sv = 0;
    chk("basic_cnt", 32'(cnt), 1);
    chk("basic_t1_valid", 32'(valid), 0);
    tick();
    chk("basic_read_addr", 32'(pop_slot), 3);
    chk("basic_read_pop", 32'(pop_en), 0);
    tick();
    chk("basic_cap_pop", 32'(pop_en), 1);
    chk("basic_cap_addr", 32'(pop_slot), 3);
    tick();
    chk("basic_valid", 32'(valid), 1);
    chk("basic_data", 32'(rdata), 32'hA5);
    chk("basic_slot", 32'(rslot), 3);
    chk("basic_pop_off", 32'(pop_en), 0);
    chk("basic_cnt0", 32'(cnt), 0);
    ready = 1; tick(); ready = 0;
    chk("basic_done", 32'(valid), 0);

    // Ordering under backpressure.
    sv = 1;
    sid = 4'd5; tick();
    sid = 4'd1; tick();
    sid = 4'd7; tick();
    sv = 0; bad = 0;
    repeat (20) begin
      tick();
      if (valid !== 1'b1 || rslot !== 4'd5) bad++;
    end
    chk("bp_hold", 32'(bad), 0);
    chk("bp_cnt", 32'(cnt), 2);
    chk("bp_data", 32'(rdata), 32'hA7);
    ready = 1; n = 0;
    repeat (30) begin
      if (valid) begin got[n] = rslot; n++; end
      tick();
    end
    ready = 0;
    chk("bp_ndisp", 32'(n), 3);
    chk("bp_o0", 32'(got[0]), 5);
    chk("bp_o1", 32'(got[1]), 1);
    chk("bp_o2", 32'(got[2]), 7);

    // Gating by initialized_in.
    init = 0; sv = 1; sid = 4'd2; tick();
    sv = 0; bad = 0;
    repeat (50) begin
      tick();
      if (pop_en !== 1'b0) bad++;
    end
    chk("gate_nopop", 32'(bad), 0);
    chk("gate_cnt", 32'(cnt), 1);
    init = 1; tick();
    chk("gate_read_pop", 32'(pop_en), 0);
    tick();
    chk("gate_cap_pop", 32'(pop_en), 1);
    chk("gate_cap_addr", 32'(pop_slot), 2);
    tick();
    chk("gate_valid", 32'(valid), 1);
    chk("gate_slot", 32'(rslot), 2);
    ready = 1; tick(); ready = 0;

    // Reset in CAPTURE with ids pending.
    init = 0; sv = 1;
    sid = 4'd4; tick();
    sid = 4'd6; tick();
    sid = 4'd8; tick();
    sv = 0;
    chk("rm_cnt3", 32'(cnt), 3);
    init = 1; tick(); tick();
    chk("rm_in_capture", 32'(pop_en), 1);
    reset = 1'b0; #1;
    chk("rm_pop_en", 32'(pop_en), 0);
    chk("rm_cnt", 32'(cnt), 0);
    chk("rm_valid", 32'(valid), 0);
    chk("rm_pop_slot", 32'(pop_slot), 0);
    chk("rm_rdata", 32'(rdata), 0);
    chk("rm_rslot", 32'(rslot), 0);
    tick();
    reset = 1'b1; bad = 0;
    repeat (10) begin
      tick();
      if (pop_en !== 1'b0 || valid !== 1'b0) bad++;
    end
    chk("rm_after", 32'(bad), 0);

    // Wrap: 40 ids through a 16-deep FIFO with ready held high.
    init = 1; ready = 1; pushed = 0; n = 0; mism = 0;
    for (int cyc = 0; cyc < 600 && n < 40; cyc++) begin
      if (valid) begin
        if (rslot !== 4'((n * 7) % 16)) mism++;
        if (rdata !== 8'hA2 + 8'((n * 7) % 16)) mism++;
        n++;
      end
      if (pushed < 40 && cnt < 5'd14) begin
        sv = 1; sid = 4'((pushed * 7) % 16); pushed++;
      end else sv = 0;
      tick();
    end
    sv = 0; ready = 0;
    chk("wrap_pushed", 32'(pushed), 40);
    chk("wrap_ndisp", 32'(n), 40);
    chk("wrap_order", 32'(mism), 0);
    chk("wrap_err", 32'(err), 0);
    chk("wrap_cnt", 32'(cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/request_dispatcher.md
REQUEST_DISPATCHER -- requirements
Module: request_dispatcher

Interface
REQ-001 Parameter DATA_WIDTH, default 8, request payload width in bits.
REQ-002 Parameter LSIZE, default 4, slot-id width; the pending FIFO depth is 2**LSIZE.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-005 initialized_in  in  1  request queue has finished initialization; no dispatch occurs while it is 0.
REQ-006 slot_valid_in  in  1  new request stored; driven from the queue push-done strobe.
REQ-007 slot_id_in  in  LSIZE  slot holding the new request.
REQ-008 pop_slot_id_out  out  LSIZE  read address into the queue.
REQ-009 pop_en_out  out  1  one-cycle strobe that frees pop_slot_id_out back to the queue.
REQ-010 pop_data_in  in  DATA_WIDTH  queue read data, valid one cycle after the address.
REQ-011 req_valid_out  out  1  dispatched request available.
REQ-012 req_ready_in  in  1  downstream accepts the request.
REQ-013 req_data_out  out  DATA_WIDTH  request payload.
REQ-014 req_slot_id_out  out  LSIZE  slot the payload came from.
REQ-015 pending_count_out  out  LSIZE+1  number of slot ids buffered in the FIFO.
REQ-016 error  out  1  sticky overflow flag.

Function
REQ-017 The block shall buffer slot ids in arrival order in a FIFO of 2**LSIZE entries and dispatch them in FIFO order.
REQ-018 A FIFO write shall occur on each cycle with slot_valid_in=1 and the FIFO not full; the entry shall be visible as non-empty on the next cycle.
REQ-019 The FSM shall have states IDLE, READ, CAPTURE and OUT.
REQ-020 IDLE->READ shall occur when the FIFO is non-empty and initialized_in=1; otherwise the FSM shall remain in IDLE.
REQ-021 In READ and CAPTURE, pop_slot_id_out shall equal the FIFO head; READ->CAPTURE shall be unconditional.
REQ-022 In CAPTURE the block shall latch pop_data_in into req_data_out and the head into req_slot_id_out, assert pop_en_out for exactly one cycle, pop the FIFO head, and go to OUT.
REQ-023 In OUT, req_valid_out shall be 1 and req_data_out/req_slot_id_out shall be held stable until req_ready_in=1.
REQ-024 On an OUT handshake, the FSM shall go to READ if the FIFO is non-empty (counting the same-cycle write) and initialized_in=1; otherwise it shall go to IDLE.
REQ-025 Latency shall be 4 cycles from slot_valid_in at cycle t to req_valid_out=1 at cycle t+4, given an empty FIFO, IDLE state and initialized_in=1.
REQ-026 Peak throughput shall be one request per 3 cycles while req_ready_in is held at 1.
REQ-027 A simultaneous FIFO write and head pop shall leave pending_count_out unchanged; read and write pointers shall wrap modulo 2**LSIZE.
REQ-028 slot_valid_in while the FIFO is full shall drop the id, leave the FIFO unchanged, and set error, which holds until reset.
REQ-029 initialized_in falling to 0 shall affect only the IDLE->READ and OUT->READ decisions; a dispatch already in progress shall complete.
REQ-030 pop_en_out shall never be asserted outside CAPTURE.

Reset
REQ-031 reset=0 shall immediately force the FSM to IDLE and the FIFO pointers and count to 0, dropping any in-flight dispatch.
REQ-032 During and after reset, pop_en_out, req_valid_out, error and pending_count_out shall be 0, and pop_slot_id_out, req_data_out and req_slot_id_out shall be all-zero.
REQ-033 Reset release shall take effect at the first clk edge after reset returns to 1.

Structure
REQ-034 The package rq_pkg shall hold the DispatchState enum and the SlotId typedef (logic[LSIZE-1:0]), shared with request_queue users.
REQ-035 The pending FIFO shall be the sub-module dispatch_slot_fifo (synchronous, same clk/reset, with count, full and empty outputs).
REQ-036 The FSM and the output register shall reside in request_dispatcher.

Verification
REQ-037 Basic: set initialized_in=1 and pulse slot_valid_in with slot_id_in=3 at cycle 10, with pop_data_in=0xA5 in CAPTURE -> req_valid_out=1 at cycle 14 with req_data_out=0xA5 and req_slot_id_out=3, and pop_en_out at cycle 13 with pop_slot_id_out=3.
REQ-038 Ordering/backpressure: push ids 5, 1, 7 back to back and hold req_ready_in=0 for 20 cycles -> req_valid_out stays 1 with slot 5 stable, pending_count_out=2; then release -> slots delivered in order 5, 1, 7.
REQ-039 Full/overflow (LSIZE=2): hold initialized_in=0 and push 5 ids -> pending_count_out=4, error=1, the 5th id is never dispatched.
REQ-040 Gating: with initialized_in=0, push id 2 -> no pop_en_out for 50 cycles; raise initialized_in -> dispatch 3 cycles later.
REQ-041 Reset mid-operation: assert reset in CAPTURE with 3 ids pending -> outputs are 0 immediately, pending_count_out=0, and there is no pop_en_out after release.
REQ-042 Wrap: stream 40 ids with req_ready_in=1 (LSIZE=4) -> 40 in-order dispatches, error=0.
